// File: rtl/spi_seq_pkg.sv
// Shared definitions for the SPI transfer sequencer.
// Register offsets, CTRL bit positions, FSM encoding and helpers.
package spi_seq_pkg;

    localparam logic [7:0] REG_RX0     = 8'h00;
    localparam logic [7:0] REG_TX0     = 8'h00;
    localparam logic [7:0] REG_CTRL    = 8'h10;
    localparam logic [7:0] REG_DIVIDER = 8'h14;
    localparam logic [7:0] REG_SS      = 8'h18;

    localparam int CTRL_GO     = 8;
    localparam int CTRL_RX_NEG = 9;
    localparam int CTRL_TX_NEG = 10;
    localparam int CTRL_LSB    = 11;
    localparam int CTRL_IE     = 12;
    localparam int CTRL_ASS    = 13;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_DIV,
        ST_WR_SS,
        ST_WR_TX,
        ST_WR_CTRL,
        ST_POLL_A,
        ST_POLL_D,
        ST_RD_A,
        ST_RD_D,
        ST_RESP
    } seq_state_e;

    // L encodes L+1 bits, so L=31 yields all ones.
    function automatic logic [31:0] len_mask(input logic [4:0] len);
        return 32'hFFFF_FFFF >> (5'd31 - len);
    endfunction

    // mode is {lsb, tx_negedge, rx_negedge}
    function automatic logic [31:0] ctrl_word(
        input logic [4:0] len,
        input logic [2:0] mode
    );
        logic [31:0] w;
        w              = '0;
        w[6:0]         = 7'(len) + 7'd1;
        w[CTRL_GO]     = 1'b1;
        w[CTRL_RX_NEG] = mode[0];
        w[CTRL_TX_NEG] = mode[1];
        w[CTRL_LSB]    = mode[2];
        w[CTRL_IE]     = 1'b0;
        w[CTRL_ASS]    = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last grant,
// pointer advances only when the grant is accepted.
module spi_rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_REQ-1:0] req,
    input  logic             accept,
    output logic [N_REQ-1:0] gnt
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] gnt_idx;
    logic          found;
    int            idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = ptr_q;
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= PW'(N_REQ - 1);
        end else if (accept && found) begin
            ptr_q <= gnt_idx;
        end
    end

endmodule

// File: rtl/spi_xfer_seq.sv
// Transfer sequencer sharing one spi_core between N_REQ requesters.
// All outputs are registered and aligned with the state they belong to.
module spi_xfer_seq
    import spi_seq_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int SS_NB = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [N_REQ-1:0]       req_valid_i,
    output logic [N_REQ-1:0]       req_ready_o,
    input  logic [N_REQ*SS_NB-1:0] req_ss_i,
    input  logic [N_REQ*5-1:0]     req_len_i,
    input  logic [N_REQ*32-1:0]    req_data_i,
    output logic [N_REQ-1:0]       rsp_valid_o,
    output logic [31:0]            rsp_data_o,
    input  logic [15:0]            cfg_divider_i,
    input  logic [2:0]             cfg_mode_i,
    output logic                   busy_o,
    output logic [7:0]             addr_o,
    output logic [31:0]            wdata_o,
    output logic [3:0]             be_o,
    output logic                   we_o,
    output logic                   re_o,
    input  logic [31:0]            rdata_i
);

    seq_state_e       state_q;
    logic [N_REQ-1:0] gnt;
    logic [N_REQ-1:0] own_q;
    logic             accept;
    logic [SS_NB-1:0] sel_ss, ss_q;
    logic [4:0]       sel_len, len_q;
    logic [31:0]      sel_data, data_q;
    logic [15:0]      div_q;
    logic [2:0]       mode_q;

    assign accept = (state_q == ST_IDLE) && (|req_valid_i);

    spi_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req    (req_valid_i),
        .accept (accept),
        .gnt    (gnt)
    );

    always_comb begin
        sel_ss   = '0;
        sel_len  = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_ss   = req_ss_i[i*SS_NB +: SS_NB];
                sel_len  = req_len_i[i*5 +: 5];
                sel_data = req_data_i[i*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            own_q       <= '0;
            ss_q        <= '0;
            len_q       <= '0;
            data_q      <= '0;
            div_q       <= '0;
            mode_q      <= '0;
            req_ready_o <= '0;
            rsp_valid_o <= '0;
            rsp_data_o  <= '0;
            busy_o      <= 1'b0;
            addr_o      <= '0;
            wdata_o     <= '0;
            be_o        <= '0;
            we_o        <= 1'b0;
            re_o        <= 1'b0;
        end else begin
            req_ready_o <= '0;
            rsp_valid_o <= '0;
            rsp_data_o  <= '0;
            addr_o      <= '0;
            wdata_o     <= '0;
            be_o        <= '0;
            we_o        <= 1'b0;
            re_o        <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (|gnt) begin
                        req_ready_o <= gnt;
                        own_q       <= gnt;
                        ss_q        <= sel_ss;
                        len_q       <= sel_len;
                        data_q      <= sel_data;
                        div_q       <= cfg_divider_i;
                        mode_q      <= cfg_mode_i;
                        busy_o      <= 1'b1;
                        state_q     <= ST_WR_DIV;
                        we_o        <= 1'b1;
                        be_o        <= 4'hF;
                        addr_o      <= REG_DIVIDER;
                        wdata_o     <= {16'b0, cfg_divider_i};
                    end
                end
                ST_WR_DIV: begin
                    state_q <= ST_WR_SS;
                    we_o    <= 1'b1;
                    be_o    <= 4'hF;
                    addr_o  <= REG_SS;
                    wdata_o <= 32'(ss_q);
                end
                ST_WR_SS: begin
                    state_q <= ST_WR_TX;
                    we_o    <= 1'b1;
                    be_o    <= 4'hF;
                    addr_o  <= REG_TX0;
                    wdata_o <= data_q;
                end
                ST_WR_TX: begin
                    state_q <= ST_WR_CTRL;
                    we_o    <= 1'b1;
                    be_o    <= 4'hF;
                    addr_o  <= REG_CTRL;
                    wdata_o <= ctrl_word(len_q, mode_q);
                end
                ST_WR_CTRL: begin
                    state_q <= ST_POLL_A;
                    re_o    <= 1'b1;
                    addr_o  <= REG_CTRL;
                end
                ST_POLL_A: begin
                    state_q <= ST_POLL_D;
                end
                ST_POLL_D: begin
                    re_o <= 1'b1;
                    if (rdata_i[CTRL_GO]) begin
                        state_q <= ST_POLL_A;
                        addr_o  <= REG_CTRL;
                    end else begin
                        state_q <= ST_RD_A;
                        addr_o  <= REG_RX0;
                    end
                end
                ST_RD_A: begin
                    state_q <= ST_RD_D;
                end
                ST_RD_D: begin
                    state_q     <= ST_RESP;
                    rsp_valid_o <= own_q;
                    rsp_data_o  <= rdata_i & len_mask(len_q);
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    busy_o  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_seq.sv
// Bench for spi_xfer_seq with a behavioural spi_core register model
// and per-requester drivers, checked against transaction-level expectations.
module tb_spi_xfer_seq;

    localparam int N  = 4;
    localparam int SS = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready_o;
    logic [N*SS-1:0] req_ss = '0;
    logic [N*5-1:0]  req_len = '0;
    logic [N*32-1:0] req_data = '0;
    logic [N-1:0]    rsp_valid_o;
    logic [31:0]     rsp_data_o;
    logic [15:0]     cfg_div = '0;
    logic [2:0]      cfg_mode = '0;
    logic            busy_o;
    logic [7:0]      addr_o;
    logic [31:0]     wdata_o;
    logic [3:0]      be_o;
    logic            we_o, re_o;
    logic [31:0]     rdata_i;

    always #5 clk = ~clk;

    spi_xfer_seq #(.N_REQ(N), .SS_NB(SS)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o),
        .req_ss_i(req_ss), .req_len_i(req_len), .req_data_i(req_data),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
        .cfg_divider_i(cfg_div), .cfg_mode_i(cfg_mode),
        .busy_o(busy_o), .addr_o(addr_o), .wdata_o(wdata_o),
        .be_o(be_o), .we_o(we_o), .re_o(re_o), .rdata_i(rdata_i)
    );

    // spi_core model: GO stays set for a random character time,
    // RX returns TX (loopback) or all ones.
    bit          slave_ones = 1'b0;
    int          go_cnt;
    logic [31:0] tx_reg, rx_reg;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_i <= '0;
            go_cnt  <= 0;
            tx_reg  <= '0;
            rx_reg  <= '0;
        end else begin
            rdata_i <= '0;
            if (re_o && addr_o == 8'h10)
                rdata_i <= (go_cnt != 0) ? 32'h100 : 32'h0;
            else if (re_o && addr_o == 8'h00)
                rdata_i <= rx_reg;
            if (go_cnt != 0) go_cnt <= go_cnt - 1;
            if (we_o && addr_o == 8'h00) tx_reg <= wdata_o;
            if (we_o && addr_o == 8'h10 && wdata_o[8]) begin
                go_cnt <= int'($urandom_range(2, 12));
                rx_reg <= slave_ones ? 32'hFFFF_FFFF : tx_reg;
            end
        end
    end

    typedef struct {
        int idx; int cyc; logic [15:0] div; logic [2:0] mode;
        logic [7:0] ss; logic [4:0] len; logic [31:0] data;
    } xfer_t;
    typedef struct {
        int cyc; logic [7:0] addr; logic [31:0] data; logic [3:0] be;
    } wr_t;
    typedef struct { int idx; int cyc; logic [31:0] data; } rsp_t;

    xfer_t gq[$];
    wr_t   wq[$];
    rsp_t  rq[$];
    int    total = 0, bad = 0, cyc = 0;
    int    viol = 0, rearm_left = 0;
    bit    in_go = 0, scramble = 0;

    function automatic logic [31:0] mask_of(input int len);
        logic [63:0] m;
        m = (64'd1 << (len + 1)) - 64'd1;
        return m[31:0];
    endfunction

    function automatic logic [31:0] exp_ctrl(input int len, input int mode);
        return 32'h2000 + 32'(mode * 512) + 32'h100 + 32'(len + 1);
    endfunction

    task automatic set_req(input int i, input logic [7:0] ss,
                           input logic [4:0] len, input logic [31:0] d);
        req_ss[i*SS +: SS]   = ss;
        req_len[i*5 +: 5]    = len;
        req_data[i*32 +: 32] = d;
        req_valid[i]         = 1'b1;
    endtask

    task automatic clear_log();
        gq.delete(); wq.delete(); rq.delete();
        viol = 0; in_go = 0;
    endtask

    // Advance one cycle, act as the requesters and log bus activity.
    task automatic step();
        xfer_t x;
        @(negedge clk);
        cyc++;
        if (we_o) begin
            if (in_go) viol++;
            wq.push_back('{cyc, addr_o, wdata_o, be_o});
            if (addr_o == 8'h10) in_go = 1;
        end
        for (int i = 0; i < N; i++) begin
            if (req_ready_o[i]) begin
                x.idx = i; x.cyc = cyc; x.div = cfg_div;
                x.mode = cfg_mode; x.ss = req_ss[i*SS +: SS];
                x.len = req_len[i*5 +: 5];
                x.data = req_data[i*32 +: 32];
                gq.push_back(x);
                req_valid[i] = 1'b0;
                if (scramble) begin
                    cfg_div  = 16'($urandom);
                    cfg_mode = 3'($urandom);
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (rsp_valid_o[i]) begin
                in_go = 0;
                rq.push_back('{i, cyc, rsp_data_o});
                if (rearm_left > 0) begin
                    rearm_left--;
                    set_req(i, 8'($urandom), 5'($urandom), $urandom);
                end
            end
        end
    endtask

    task automatic run_until(input int n, input int budget, output bit ok);
        int c = 0;
        while (rq.size() < n && c < budget) begin
            step();
            c++;
        end
        ok = (rq.size() >= n);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++; if (req_ready_o !== '0) begin bad++; $display("FAIL rst_ready got=%h exp=0", req_ready_o); end
        total++; if (rsp_valid_o !== '0) begin bad++; $display("FAIL rst_rsp_valid got=%h exp=0", rsp_valid_o); end
        total++; if (rsp_data_o !== '0) begin bad++; $display("FAIL rst_rsp_data got=%h exp=0", rsp_data_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
        total++; if ({we_o, re_o} !== 2'b00) begin bad++; $display("FAIL rst_we_re got=%b exp=00", {we_o, re_o}); end
        total++; if ({addr_o, wdata_o, be_o} !== '0) begin bad++; $display("FAIL rst_bus got=%h exp=0", {addr_o, wdata_o, be_o}); end
        rst_n = 1'b1;
        clear_log();
    endtask

    task automatic test_single();
        bit ok;
        cfg_div = 16'd2; cfg_mode = 3'd0; slave_ones = 0;
        clear_log();
        set_req(0, 8'h01, 5'd7, 32'h0000_00A5);
        run_until(1, 400, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_timeout got=%0d exp=1 responses", rq.size()); end
        total++; if (wq.size() != 4) begin bad++; $display("FAIL single_nwrites got=%0d exp=4", wq.size()); end
        if (wq.size() >= 4 && gq.size() >= 1) begin
            total++; if (wq[0].addr !== 8'h14 || wq[0].data !== 32'h2) begin bad++; $display("FAIL single_div got=%h<-%h exp=14<-2", wq[0].addr, wq[0].data); end
            total++; if (wq[1].addr !== 8'h18 || wq[1].data !== 32'h1) begin bad++; $display("FAIL single_ss got=%h<-%h exp=18<-1", wq[1].addr, wq[1].data); end
            total++; if (wq[2].addr !== 8'h00 || wq[2].data !== 32'hA5) begin bad++; $display("FAIL single_tx got=%h<-%h exp=00<-a5", wq[2].addr, wq[2].data); end
            total++; if (wq[3].addr !== 8'h10 || wq[3].data !== 32'h2108) begin bad++; $display("FAIL single_ctrl got=%h<-%h exp=10<-2108", wq[3].addr, wq[3].data); end
            total++; if (wq[0].be !== 4'hF) begin bad++; $display("FAIL single_be got=%h exp=f", wq[0].be); end
            total++; if (wq[0].cyc != gq[0].cyc) begin bad++; $display("FAIL single_first_write got=cyc%0d exp=cyc%0d", wq[0].cyc, gq[0].cyc); end
        end
        if (rq.size() >= 1) begin
            total++; if (rq[0].idx != 0) begin bad++; $display("FAIL single_rsp_idx got=%0d exp=0", rq[0].idx); end
            total++; if (rq[0].data !== 32'h0000_00A5) begin bad++; $display("FAIL single_rsp_data got=%h exp=000000a5", rq[0].data); end
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int expg;
        test_reset();
        cfg_div = 16'($urandom); cfg_mode = 3'($urandom);
        for (int i = 0; i < N; i++)
            set_req(i, 8'($urandom), 5'($urandom), $urandom);
        rearm_left = N;
        run_until(2 * N, 2000, ok);
        total++; if (!ok) begin bad++; $display("FAIL rr_timeout got=%0d exp=%0d responses", rq.size(), 2 * N); end
        total++; if (gq.size() != 2 * N) begin bad++; $display("FAIL rr_accepts got=%0d exp=%0d", gq.size(), 2 * N); end
        total++; if (wq.size() != 8 * N) begin bad++; $display("FAIL rr_nwrites got=%0d exp=%0d", wq.size(), 8 * N); end
        total++; if (viol != 0) begin bad++; $display("FAIL rr_write_in_flight got=%0d exp=0", viol); end
        expg = N - 1;
        for (int k = 0; k < gq.size() && k < rq.size(); k++) begin
            expg = (expg + 1) % N;
            total++; if (gq[k].idx != expg) begin bad++; $display("FAIL rr_grant%0d got=%0d exp=%0d", k, gq[k].idx, expg); end
            total++; if (rq[k].idx != gq[k].idx) begin bad++; $display("FAIL rr_rsp_owner%0d got=%0d exp=%0d", k, rq[k].idx, gq[k].idx); end
            total++; if (rq[k].data !== (gq[k].data & mask_of(gq[k].len))) begin bad++; $display("FAIL rr_rsp_data%0d got=%h exp=%h", k, rq[k].data, gq[k].data & mask_of(gq[k].len)); end
            if (wq.size() >= 4 * k + 4) begin
                total++; if (wq[4*k].data !== {16'h0, gq[k].div}) begin bad++; $display("FAIL rr_div%0d got=%h exp=%h", k, wq[4*k].data, gq[k].div); end
                total++; if (wq[4*k+1].data !== {24'h0, gq[k].ss}) begin bad++; $display("FAIL rr_ss%0d got=%h exp=%h", k, wq[4*k+1].data, gq[k].ss); end
                total++; if (wq[4*k+2].data !== gq[k].data) begin bad++; $display("FAIL rr_tx%0d got=%h exp=%h", k, wq[4*k+2].data, gq[k].data); end
                total++; if (wq[4*k+3].data !== exp_ctrl(int'(gq[k].len), int'(gq[k].mode))) begin bad++; $display("FAIL rr_ctrl%0d got=%h exp=%h", k, wq[4*k+3].data, exp_ctrl(int'(gq[k].len), int'(gq[k].mode))); end
            end
        end
    endtask

    task automatic test_mask();
        bit ok;
        int len;
        logic [31:0] expd;
        clear_log();
        slave_ones = 1;
        for (int k = 0; k < 6; k++) begin
            if (k == 0) len = 3;
            else if (k == 1) len = 31;
            else len = int'($urandom_range(0, 31));
            if (k == 0) expd = 32'h0000_000F;
            else if (k == 1) expd = 32'hFFFF_FFFF;
            else expd = mask_of(len);
            set_req(k % N, 8'($urandom), 5'(len), $urandom);
            run_until(k + 1, 400, ok);
            total++; if (!ok || rq[k].data !== expd) begin bad++; $display("FAIL mask_L%0d got=%h exp=%h", len, ok ? rq[k].data : 32'hx, expd); end
        end
        slave_ones = 0;
    endtask

    task automatic test_mode();
        bit ok;
        int i, len;
        clear_log();
        i = int'($urandom_range(0, N - 1));
        len = int'($urandom_range(0, 31));
        cfg_mode = 3'b111; cfg_div = 16'($urandom);
        scramble = 1;
        set_req(i, 8'($urandom), 5'(len), $urandom);
        run_until(1, 400, ok);
        scramble = 0;
        total++; if (!ok || wq.size() != 4) begin bad++; $display("FAIL mode_nwrites got=%0d exp=4", wq.size()); end
        if (wq.size() >= 4 && gq.size() >= 1) begin
            total++; if (wq[3].data !== (32'h2E00 | 32'h100 | 32'(len + 1))) begin bad++; $display("FAIL mode_ctrl got=%h exp=%h", wq[3].data, 32'h2E00 | 32'h100 | 32'(len + 1)); end
            total++; if (wq[0].data !== {16'h0, gq[0].div}) begin bad++; $display("FAIL mode_div_held got=%h exp=%h", wq[0].data, gq[0].div); end
        end
        total++; if (viol != 0) begin bad++; $display("FAIL mode_write_in_flight got=%0d exp=0", viol); end
    endtask

    task automatic test_reset_mid();
        bit ok, seen, stray;
        int c;
        clear_log();
        cfg_mode = 3'($urandom);
        set_req(1, 8'h02, 5'($urandom), $urandom);
        seen = 0; c = 0;
        while (!seen && c < 200) begin
            step();
            c++;
            seen = (re_o === 1'b1 && addr_o === 8'h10);
        end
        total++; if (!seen) begin bad++; $display("FAIL rmid_poll_timeout got=none exp=POLL_A"); end
        rst_n = 1'b0;
        req_valid = '0;
        #1;
        total++; if ({busy_o, we_o, re_o, rsp_valid_o, req_ready_o} !== '0) begin bad++; $display("FAIL rmid_outputs got=%h exp=0", {busy_o, we_o, re_o, rsp_valid_o, req_ready_o}); end
        total++; if ({addr_o, wdata_o, be_o, rsp_data_o} !== '0) begin bad++; $display("FAIL rmid_bus got=%h exp=0", {addr_o, wdata_o, be_o, rsp_data_o}); end
        stray = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid_o !== '0) stray = 1;
        end
        total++; if (stray) begin bad++; $display("FAIL rmid_stray_rsp got=1 exp=0"); end
        rst_n = 1'b1;
        clear_log();
        set_req(2, 8'h04, 5'($urandom), $urandom);
        run_until(1, 400, ok);
        total++; if (!ok || gq.size() < 1 || gq[0].idx != 2) begin bad++; $display("FAIL rmid_regrant got=%0d exp=2", gq.size() > 0 ? gq[0].idx : -1); end
        if (ok && gq.size() >= 1) begin
            total++; if (rq[0].idx != 2 || rq[0].data !== (gq[0].data & mask_of(gq[0].len))) begin bad++; $display("FAIL rmid_rsp got=%0d:%h exp=2:%h", rq[0].idx, rq[0].data, gq[0].data & mask_of(gq[0].len)); end
        end
    endtask

    task automatic test_back_to_back();
        int c, low;
        clear_log();
        set_req(1, 8'($urandom), 5'($urandom), $urandom);
        rearm_left = 1;
        c = 0; low = 0;
        while (rq.size() < 2 && c < 800) begin
            step();
            c++;
            if (rq.size() == 1 && gq.size() == 1 && busy_o === 1'b0) low++;
        end
        total++; if (rq.size() != 2) begin bad++; $display("FAIL b2b_timeout got=%0d exp=2 responses", rq.size()); end
        total++; if (gq.size() != 2 || gq[0].idx != 1 || gq[1].idx != 1) begin bad++; $display("FAIL b2b_grants got=%0d exp=2 grants to 1", gq.size()); end
        total++; if (low != 1) begin bad++; $display("FAIL b2b_idle_gap got=%0d exp=1", low); end
        for (int k = 0; k < rq.size() && k < gq.size(); k++) begin
            total++; if (rq[k].data !== (gq[k].data & mask_of(gq[k].len))) begin bad++; $display("FAIL b2b_data%0d got=%h exp=%h", k, rq[k].data, gq[k].data & mask_of(gq[k].len)); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_mask();
        test_mode();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
